reg_file_param: RTL and testbench

Parametrised multi-port register file, the next generation of the processor's 32x32 two-read/one-write register file. It generalises data width, depth and read-port count, and adds four things: byte-enable writes, optional write-to-read bypass, an optional hardwired zero register, and a sequential clear engine. The clear engine scrubs the array one entry per cycle after reset or on request. The block sits in the decode stage, feeding operand buses and accepting write-back data.

---
 rtl/reg_file_param.sv | 102 ++++++++++
 tb/tb_reg_file_param.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parametrised multi-port register file with byte-enable writes, optional
// write-to-read bypass, optional hardwired zero entry and a sequential clear engine.
module reg_file_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           clearRequest,
    input  logic                           writeEnable,
    input  logic [DATA_WIDTH/8-1:0]        byteEnable,
    input  logic [ADDR_WIDTH-1:0]          writeAddress,
    input  logic [DATA_WIDTH-1:0]          writeData,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] readAddress,
    output logic [NUM_READ*DATA_WIDTH-1:0] readData,
    output logic                           ready
);

    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clear_count;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   merged;
    logic                    write_active;

    // A write is effective only in RUN, without a competing clear request,
    // and never to the hardwired zero entry.
    assign write_active = (state == RUN) && writeEnable && !clearRequest &&
                          !((ZERO_REG != 0) && (writeAddress == '0));

    assign ready = (state == RUN);

    always_comb begin
        merged = mem[writeAddress];
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (byteEnable[i]) begin
                merged[8*i +: 8] = writeData[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clear_count == '1) state_next = RUN;
            RUN:     if (clearRequest)      state_next = CLEAR;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= CLEAR;
            clear_count <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                clear_count <= clear_count + 1'b1;
            end else if (clearRequest) begin
                clear_count <= '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clear_count] <= '0;
            end else if (write_active) begin
                mem[writeAddress] <= merged;
            end
        end
    end

    always_comb begin
        readData = '0;
        for (int unsigned k = 0; k < NUM_READ; k++) begin
            if ((state == RUN) &&
                !((ZERO_REG != 0) && (readAddress[k*ADDR_WIDTH +: ADDR_WIDTH] == '0))) begin
                if ((BYPASS != 0) && write_active &&
                    (readAddress[k*ADDR_WIDTH +: ADDR_WIDTH] == writeAddress)) begin
                    readData[k*DATA_WIDTH +: DATA_WIDTH] = merged;
                end else begin
                    readData[k*DATA_WIDTH +: DATA_WIDTH] =
                        mem[readAddress[k*ADDR_WIDTH +: ADDR_WIDTH]];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: a default instance and a narrow 4-port instance
// without zero register or bypass, both checked against a behavioural model.
module tb_reg_file_param;

    logic        clock = 1'b0;
    logic        rst   = 1'b0;
    logic        clr   = 1'b0;
    logic        we    = 1'b0;
    logic [3:0]  be    = '0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [9:0]  raddr_a = '0;
    logic [11:0] raddr_b = '0;
    logic [63:0] rd_a;
    logic [63:0] rd_b;
    logic        ready_a;
    logic        ready_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    reg_file_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .clock(clock), .reset(rst), .clearRequest(clr), .writeEnable(we),
        .byteEnable(be), .writeAddress(waddr), .writeData(wdata),
        .readAddress(raddr_a), .readData(rd_a), .ready(ready_a)
    );

    reg_file_param #(
        .DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(4), .ZERO_REG(0), .BYPASS(0)
    ) dut_b (
        .clock(clock), .reset(rst), .clearRequest(clr), .writeEnable(we),
        .byteEnable(be[1:0]), .writeAddress(waddr[2:0]), .writeData(wdata[15:0]),
        .readAddress(raddr_b), .readData(rd_b), .ready(ready_b)
    );

    // Per-instance configuration (m=0: dut_a, m=1: dut_b)
    function automatic int dwid(int m);  return (m == 0) ? 32 : 16; endfunction
    function automatic int depth(int m); return (m == 0) ? 32 : 8;  endfunction
    function automatic int nread(int m); return (m == 0) ? 2 : 4;   endfunction
    function automatic bit zreg(int m);  return (m == 0);            endfunction
    function automatic bit bypass(int m); return (m == 0);           endfunction

    // Model: an array of stored values plus the number of clear cycles still to run.
    int unsigned clear_left [2];
    logic [31:0] mem [2][32];
    bit          model_on = 1'b0;

    function automatic logic [31:0] dmask(int m);
        return (m == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    function automatic int wa(int m);
        return int'(waddr) % depth(m);
    endfunction

    function automatic logic [31:0] merge(int m, logic [31:0] old);
        logic [31:0] v = old;
        for (int i = 0; i < dwid(m) / 8; i++)
            if (be[i]) v[8*i +: 8] = wdata[8*i +: 8];
        return v & dmask(m);
    endfunction

    function automatic bit write_eff(int m);
        return (clear_left[m] == 0) && we && !clr && !(zreg(m) && wa(m) == 0);
    endfunction

    function automatic logic [31:0] exp_read(int m, int k);
        int a = (m == 0) ? int'(raddr_a[k*5 +: 5]) : int'(raddr_b[k*3 +: 3]);
        if (clear_left[m] != 0) return '0;
        if (zreg(m) && a == 0) return '0;
        if (bypass(m) && write_eff(m) && a == wa(m)) return merge(m, mem[m][a]);
        return mem[m][a] & dmask(m);
    endfunction

    function automatic logic [31:0] act_read(int m, int k);
        return (m == 0) ? rd_a[k*32 +: 32] : {16'h0, rd_b[k*16 +: 16]};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                clear_left[m] <= depth(m);
                for (int i = 0; i < 32; i++) mem[m][i] <= '0;
            end else if (model_on) begin
                if (clear_left[m] != 0) begin
                    clear_left[m] <= clear_left[m] - 1;
                end else if (clr) begin
                    clear_left[m] <= depth(m);
                    for (int i = 0; i < 32; i++) mem[m][i] <= '0;
                end else if (write_eff(m)) begin
                    mem[m][wa(m)] <= merge(m, mem[m][wa(m)]);
                end
            end
        end
        if (rst) model_on <= 1'b1;
    end

    always @(negedge clock) begin
        if (model_on) begin
            check("ready_a", {31'h0, ready_a}, {31'h0, clear_left[0] == 0});
            check("ready_b", {31'h0, ready_b}, {31'h0, clear_left[1] == 0});
            for (int m = 0; m < 2; m++)
                for (int k = 0; k < nread(m); k++)
                    check($sformatf("read_m%0d_p%0d", m, k), act_read(m, k), exp_read(m, k));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic count_low(string name, int exp_a, int exp_b);
        int low_a = 0;
        int low_b = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clock);
            if (!ready_a) low_a++;
            if (!ready_b) low_b++;
        end
        check({name, "_low_a"}, low_a, exp_a);
        check({name, "_low_b"}, low_b, exp_b);
    endtask

    initial begin
        // Reset clear timing
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_low("reset", 32, 8);

        // Byte writes
        tick();
        we = 1'b1; waddr = 5'd1; wdata = 32'hFFFF_FFFF; be = 4'b1111;
        tick();
        wdata = 32'h0001_0000; be = 4'b0100;
        tick();
        we = 1'b0; raddr_a = {5'd0, 5'd1}; raddr_b = {3'd0, 3'd0, 3'd0, 3'd1};
        @(negedge clock);
        check("byte_a", rd_a[31:0], 32'hFF01_FFFF);
        check("byte_b", {16'h0, rd_b[15:0]}, 32'h0000_FFFF);

        // Zero register
        tick();
        we = 1'b1; waddr = 5'd0; wdata = 32'hDEAD_BEEF; be = 4'b1111;
        tick();
        we = 1'b0; raddr_a = '0; raddr_b = '0;
        @(negedge clock);
        check("zero_a_p0", rd_a[31:0], 32'h0);
        check("zero_a_p1", rd_a[63:32], 32'h0);
        check("zero_b_p0", {16'h0, rd_b[15:0]}, 32'h0000_BEEF);

        // Bypass versus registered read
        tick();
        we = 1'b1; waddr = 5'd4; wdata = 32'h1234_5678; be = 4'b1111;
        raddr_a = {5'd4, 5'd0}; raddr_b = {3'd0, 3'd0, 3'd4, 3'd0};
        @(negedge clock);
        check("bypass_a_pre", rd_a[63:32], 32'h1234_5678);
        check("bypass_b_pre", {16'h0, rd_b[31:16]}, 32'h0);
        tick();
        we = 1'b0;
        @(negedge clock);
        check("bypass_a_post", rd_a[63:32], 32'h1234_5678);
        check("bypass_b_post", {16'h0, rd_b[31:16]}, 32'h0000_5678);

        // Clear request dropping a concurrent write
        tick();
        we = 1'b1; waddr = 5'd5; wdata = 32'hA5A5_A5A5; be = 4'b1111;
        tick();
        we = 1'b0; raddr_a = {5'd6, 5'd5}; raddr_b = {3'd0, 3'd0, 3'd6, 3'd5};
        @(negedge clock);
        check("r5_set_a", rd_a[31:0], 32'hA5A5_A5A5);
        tick();
        we = 1'b1; waddr = 5'd6; wdata = 32'h1; clr = 1'b1;
        tick();
        we = 1'b0; clr = 1'b0;
        count_low("clrreq", 32, 8);
        check("clr_r5_a", rd_a[31:0], 32'h0);
        check("clr_r6_a", rd_a[63:32], 32'h0);
        check("clr_r5_b", {16'h0, rd_b[15:0]}, 32'h0);
        check("clr_r6_b", {16'h0, rd_b[31:16]}, 32'h0);

        // Reset ten cycles into a clear restarts it
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_low("midclr", 32, 8);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst     = ($urandom_range(0, 599) == 0);
            clr     = ($urandom_range(0, 199) == 0);
            we      = $urandom_range(0, 1) == 1;
            be      = 4'($urandom_range(0, 15));
            waddr   = 5'($urandom_range(0, 31));
            wdata   = $urandom;
            raddr_a = 10'($urandom_range(0, 1023));
            raddr_b = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) == 0) raddr_a[9:5] = waddr;
            if ($urandom_range(0, 3) == 0) raddr_b[5:3] = waddr[2:0];
        end
        tick();
        rst = 1'b0; clr = 1'b0; we = 1'b0;
        tick();
        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
